// File: rtl/program_loader.sv
// Program loader: streams an image into memory, primes the fetch/decode pipe, then runs word_count instructions.
// Build macro PROGRAM_LOADER_CHECKSUM_EN enables the running XOR checksum of loaded words.
module program_loader #(
   parameter int                DATA_W        = 32,
   parameter int                ADDR_W        = 32,
   parameter logic [ADDR_W-1:0] START_ADDRESS = 32'h80020000,
   parameter int                MAX_WORDS     = 1024,
   localparam int               CNT_W         = $clog2(MAX_WORDS + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   output logic              mem_enable,
   output logic [1:0]        mem_acc_size,
   input  logic              mem_busy,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              stall,
   output logic [ADDR_W-1:0] pc_dec,
   output logic [ADDR_W-1:0] pc_exec,
   output logic              valid_insn,
   output logic [CNT_W-1:0]  word_count,
   output logic              overflow,
   output logic              run_done,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [2:0] {IDLE, LOAD, PRIME0, PRIME1, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_t            state_q, state_d;
   logic              fin_q, fin_d;
   logic              s_ready_q, s_ready_d;
   logic              stall_q, stall_d;
   logic              wren_q, wren_d;
   logic              en_q, en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] pc_dec_q, pc_dec_d;
   logic [ADDR_W-1:0] pc_exec_q, pc_exec_d;
   logic              vld_q, vld_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  run_q, run_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   logic              accept, clr, exec_q, exec_d;
   logic [ADDR_W-1:0] wr_addr;
   logic [CNT_W-1:0]  cnt_inc, run_inc;

   assign accept  = s_valid && s_ready_q;
   assign clr     = ((state_q == IDLE) || (state_q == DONE)) && start;
   assign exec_q  = (state_q == PRIME0) || (state_q == PRIME1) || (state_q == RUN);
   assign wr_addr = START_ADDRESS + (ADDR_W'(cnt_q) << 2);
   assign cnt_inc = cnt_q + 1'b1;
   assign run_inc = run_q + 1'b1;

   // fin_q marks the write cycle of the final word; the FSM leaves LOAD one cycle later
   always_comb begin
      state_d   = state_q;
      fin_d     = fin_q;
      wren_d    = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      pc_dec_d  = pc_dec_q;
      pc_exec_d = pc_exec_q;
      vld_d     = vld_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      ovf_d     = ovf_q;
      done_d    = done_q;
      if (clr) begin
         state_d = LOAD;
         fin_d   = 1'b0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         done_d  = 1'b0;
         vld_d   = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (fin_q) begin
                  state_d = PRIME0;
                  run_d   = '0;
               end else if (accept) begin
                  wren_d = 1'b1;
                  addr_d = wr_addr;
                  data_d = s_data;
                  cnt_d  = cnt_inc;
                  if (s_last) begin
                     fin_d = 1'b1;
                  end else if (cnt_inc == MAX_CNT) begin
                     fin_d = 1'b1;
                     ovf_d = 1'b1;
                  end
               end
            end
            PRIME0, PRIME1, RUN: begin
               if (!mem_busy) begin
                  addr_d    = fetch_pc;
                  pc_exec_d = fetch_pc;
                  pc_dec_d  = pc_exec_q;
                  if (state_q == PRIME0) begin
                     state_d = PRIME1;
                  end else if (state_q == PRIME1) begin
                     state_d = RUN;
                  end else begin
                     run_d = run_inc;
                     if (run_inc == cnt_q) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                     end else begin
                        vld_d = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
      exec_d    = (state_d == PRIME0) || (state_d == PRIME1) || (state_d == RUN);
      s_ready_d = (state_d == LOAD) && !fin_d && !mem_busy && (cnt_d < MAX_CNT);
      stall_d   = !exec_d || (exec_q && mem_busy);
      en_d      = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         fin_q     <= 1'b0;
         s_ready_q <= 1'b0;
         stall_q   <= 1'b1;
         wren_q    <= 1'b0;
         en_q      <= 1'b0;
         addr_q    <= START_ADDRESS;
         data_q    <= '0;
         pc_dec_q  <= '0;
         pc_exec_q <= '0;
         vld_q     <= 1'b0;
         cnt_q     <= '0;
         run_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         fin_q     <= fin_d;
         s_ready_q <= s_ready_d;
         stall_q   <= stall_d;
         wren_q    <= wren_d;
         en_q      <= en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pc_dec_q  <= pc_dec_d;
         pc_exec_q <= pc_exec_d;
         vld_q     <= vld_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
   logic              wr;

   assign wr = (state_q == LOAD) && !fin_q && accept;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)    csum_q <= '0;
      else if (clr) csum_q <= '0;
      else if (wr)  csum_q <= csum_q ^ s_data;
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

   assign s_ready      = s_ready_q;
   assign stall        = stall_q;
   assign mem_wren     = wren_q;
   assign mem_enable   = en_q;
   assign mem_addr     = addr_q;
   assign mem_data     = data_q;
   assign mem_acc_size = 2'b00;
   assign pc_dec       = pc_dec_q;
   assign pc_exec      = pc_exec_q;
   assign valid_insn   = vld_q;
   assign word_count   = cnt_q;
   assign overflow     = ovf_q;
   assign run_done     = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader (MAX_WORDS=4): phase-level model checked every cycle plus directed literal checks.
module tb_program_loader;

   localparam int          MW    = 4;
   localparam logic [31:0] START = 32'h80020000;

   logic        clock = 1'b0;
   logic        reset, start, s_valid, s_last, mem_busy;
   logic [31:0] s_data, fetch_pc;
   logic        s_ready, mem_wren, mem_enable, stall, valid_insn, overflow, run_done;
   logic [31:0] mem_addr, mem_data, pc_dec, pc_exec, checksum;
   logic [1:0]  mem_acc_size;
   logic [2:0]  word_count;

   program_loader #(.MAX_WORDS(MW)) dut (
      .clock(clock), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_wren(mem_wren), .mem_enable(mem_enable), .mem_acc_size(mem_acc_size),
      .mem_busy(mem_busy), .fetch_pc(fetch_pc), .stall(stall), .pc_dec(pc_dec),
      .pc_exec(pc_exec), .valid_insn(valid_insn), .word_count(word_count),
      .overflow(overflow), .run_done(run_done), .checksum(checksum)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 1'b0;
   int busy_left = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: load phase tracks accepted words; execution tracks advancing cycles (2 priming + word_count runs)
   typedef enum int {M_IDLE, M_LOAD, M_TAIL, M_EXEC, M_DONE} mmode_t;
   mmode_t      mode;
   int          m_cnt, m_adv;
   bit          m_ovf, m_dn, m_wren, m_vld, m_stl, m_en, m_rdy, m_acc, m_was_exec;
   logic [31:0] m_addr, m_data, m_pcx, m_pcd, m_csum;

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            mode = M_IDLE; m_cnt = 0; m_adv = 0; m_ovf = 0; m_dn = 0; m_wren = 0;
            m_vld = 0; m_stl = 1; m_en = 0; m_rdy = 0;
            m_addr = START; m_data = 0; m_pcx = 0; m_pcd = 0; m_csum = 0;
         end else begin
            m_acc      = s_valid && m_rdy;
            m_was_exec = (mode == M_EXEC);
            m_wren     = 0;
            case (mode)
               M_IDLE, M_DONE: if (start) begin
                  mode = M_LOAD; m_cnt = 0; m_ovf = 0; m_dn = 0; m_csum = 0;
               end
               M_LOAD: if (m_acc) begin
                  m_wren = 1; m_addr = START + 32'(4 * m_cnt); m_data = s_data;
                  m_cnt++; m_csum = m_csum ^ s_data;
                  if (s_last || m_cnt == MW) begin
                     mode = M_TAIL; m_ovf = !s_last;
                  end
               end
               M_TAIL: begin mode = M_EXEC; m_adv = 0; end
               M_EXEC: if (!mem_busy) begin
                  m_adv++; m_pcd = m_pcx; m_pcx = fetch_pc; m_addr = fetch_pc;
                  if (m_adv == m_cnt + 2) begin mode = M_DONE; m_dn = 1; end
               end
               default: ;
            endcase
            m_vld = (mode == M_EXEC) && (m_adv >= 3);
            m_stl = (mode != M_EXEC) || (m_was_exec && mem_busy);
            m_en  = (mode != M_IDLE);
            m_rdy = (mode == M_LOAD) && !mem_busy && (m_cnt < MW);
         end
      end
   end

   function automatic logic [31:0] exp_csum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      return m_csum;
`else
      return 32'h0;
`endif
   endfunction

   initial begin
      forever begin
         @(negedge clock);
         if (armed) begin
            chk("s_ready",      64'(s_ready),      64'(m_rdy));
            chk("stall",        64'(stall),        64'(m_stl));
            chk("mem_wren",     64'(mem_wren),     64'(m_wren));
            chk("mem_enable",   64'(mem_enable),   64'(m_en));
            chk("mem_acc_size", 64'(mem_acc_size), 64'd0);
            chk("mem_addr",     64'(mem_addr),     64'(m_addr));
            chk("mem_data",     64'(mem_data),     64'(m_data));
            chk("pc_exec",      64'(pc_exec),      64'(m_pcx));
            chk("pc_dec",       64'(pc_dec),       64'(m_pcd));
            chk("valid_insn",   64'(valid_insn),   64'(m_vld));
            chk("word_count",   64'(word_count),   64'(m_cnt));
            chk("overflow",     64'(overflow),     64'(m_ovf));
            chk("run_done",     64'(run_done),     64'(m_dn));
            chk("checksum",     64'(checksum),     64'(exp_csum()));
         end
      end
   end

   logic [31:0] wa[$], wd[$];
   initial begin
      forever begin
         @(negedge clock);
         if (mem_wren) begin wa.push_back(mem_addr); wd.push_back(mem_data); end
      end
   end

   task automatic step();
      @(negedge clock);
      if (!stall) fetch_pc = fetch_pc + 32'd4;
      if (busy_left > 0) begin mem_busy = 1'b1; busy_left--; end
      else mem_busy = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; fetch_pc = START;
      wa.delete(); wd.delete();
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] w, input bit last, input int lim, output bit ok);
      int n; bit hit;
      n = 0; ok = 1'b0;
      s_valid = 1'b1; s_data = w; s_last = last;
      while (!ok && n < lim) begin
         hit = s_ready;
         step();
         n++;
         ok = hit;
      end
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!run_done && n < lim) begin step(); n++; end
      chk("run_done_reached", 64'(run_done), 64'd1);
   endtask

   logic [31:0] img [4];
   bit ok;
   int nv, ns, cyc;
   bit first;

   initial begin
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      mem_busy = 1'b0; fetch_pc = START;
      img[0] = 32'hDEADBEEF; img[1] = 32'h12345678; img[2] = 32'h0F0F0F0F; img[3] = 32'hA5A5A5A5;
      step(); step();
      armed = 1'b1;
      step();
      chk("rst_mem_addr", 64'(mem_addr), 64'h80020000);
      chk("rst_stall",    64'(stall),    64'd1);
      chk("rst_enable",   64'(mem_enable), 64'd0);
      chk("rst_s_ready",  64'(s_ready),  64'd0);
      #2 reset = 1'b0;
      step();

      // 4-word image, last on word 4 at capacity: overflow must stay clear
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         send(img[i], i == 3, 20, ok);
         chk("t1_accept", 64'(ok), 64'd1);
      end
      nv = 0; ns = 0; cyc = 0; first = 1'b1;
      while (!run_done && cyc < 40) begin
         step(); cyc++;
         if (valid_insn) begin
            if (first) begin
               chk("t1_first_pc_exec", 64'(pc_exec), 64'h8002000C);
               chk("t1_first_pc_dec",  64'(pc_dec),  64'h80020008);
               first = 1'b0;
            end
            nv++;
         end
         if (!stall) ns++;
      end
      chk("t1_run_done", 64'(run_done), 64'd1);
      chk("t1_valid_cycles", 64'(nv), 64'd3);
      chk("t1_nostall_cycles", 64'(ns), 64'd6);
      chk("t1_done_stall", 64'(stall), 64'd1);
      chk("t1_nwrites", 64'(wa.size()), 64'd4);
      if (wa.size() == 4) begin
         chk("t1_addr0", 64'(wa[0]), 64'h80020000);
         chk("t1_addr1", 64'(wa[1]), 64'h80020004);
         chk("t1_addr2", 64'(wa[2]), 64'h80020008);
         chk("t1_addr3", 64'(wa[3]), 64'h8002000C);
         chk("t1_data3", 64'(wd[3]), 64'hA5A5A5A5);
      end
      chk("t1_word_count", 64'(word_count), 64'd4);
      chk("t1_overflow", 64'(overflow), 64'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk("t1_checksum", 64'(checksum), 64'h6633423D);
`else
      chk("t1_checksum", 64'(checksum), 64'h0);
`endif

      // restart from DONE with memory busy mid-load and mid-run
      pulse_start();
      send(32'h00000011, 1'b0, 20, ok); chk("t2_acc0", 64'(ok), 64'd1);
      busy_left = 3;
      send(32'h00000022, 1'b0, 20, ok); chk("t2_acc1", 64'(ok), 64'd1);
      send(32'h00000044, 1'b1, 20, ok); chk("t2_acc2", 64'(ok), 64'd1);
      step(); step(); step();
      busy_left = 2;
      wait_done(40);
      chk("t2_nwrites", 64'(wa.size()), 64'd3);
      if (wa.size() == 3) begin
         chk("t2_addr2", 64'(wa[2]), 64'h80020008);
         chk("t2_data1", 64'(wd[1]), 64'h00000022);
         chk("t2_data2", 64'(wd[2]), 64'h00000044);
      end

      // capacity overflow: 4 words without last, 5th must be refused
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         send(32'h100 + 32'(i), 1'b0, 20, ok);
         chk("t3_accept", 64'(ok), 64'd1);
      end
      send(32'h00000105, 1'b0, 8, ok);
      chk("t3_word5_refused", 64'(ok), 64'd0);
      chk("t3_overflow", 64'(overflow), 64'd1);
      chk("t3_nwrites", 64'(wa.size()), 64'd4);
      wait_done(40);

      // reset in the middle of RUN, then reload
      pulse_start();
      for (int i = 0; i < 3; i++) send(img[i], i == 2, 20, ok);
      cyc = 0;
      while (stall && cyc < 20) begin step(); cyc++; end
      chk("t4_exec_reached", 64'(stall), 64'd0);
      step(); step();
      #2 reset = 1'b1;
      #1;
      chk("t4_rst_s_ready",  64'(s_ready),    64'd0);
      chk("t4_rst_stall",    64'(stall),      64'd1);
      chk("t4_rst_wren",     64'(mem_wren),   64'd0);
      chk("t4_rst_enable",   64'(mem_enable), 64'd0);
      chk("t4_rst_addr",     64'(mem_addr),   64'h80020000);
      chk("t4_rst_data",     64'(mem_data),   64'd0);
      chk("t4_rst_pc_dec",   64'(pc_dec),     64'd0);
      chk("t4_rst_pc_exec",  64'(pc_exec),    64'd0);
      chk("t4_rst_valid",    64'(valid_insn), 64'd0);
      chk("t4_rst_count",    64'(word_count), 64'd0);
      chk("t4_rst_overflow", 64'(overflow),   64'd0);
      chk("t4_rst_done",     64'(run_done),   64'd0);
      chk("t4_rst_checksum", 64'(checksum),   64'd0);
      step();
      #2 reset = 1'b0;
      step();
      pulse_start();
      send(32'h00C0FFEE, 1'b1, 20, ok);
      step();
      chk("t4_nwrites", 64'(wa.size()), 64'd1);
      if (wa.size() == 1) chk("t4_reload_addr", 64'(wa[0]), 64'h80020000);
      wait_done(40);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory/instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter START_ADDRESS, default 32'h80020000, first load address and initial PC.
REQ-004 SHALL have parameter MAX_WORDS, default 1024, image capacity in words; CNT_W = clog2(MAX_WORDS+1).
REQ-005 SHALL have ports:
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  start  in  1  begin new load (IDLE/DONE only)
  s_valid  in  1  image word offered
  s_data  in  DATA_W  image word
  s_last  in  1  final image word
  s_ready  out  1  word accepted when s_valid&&s_ready
  mem_addr  out  ADDR_W  memory address
  mem_data  out  DATA_W  memory write data
  mem_wren  out  1  memory write strobe
  mem_enable  out  1  memory enable
  mem_acc_size  out  2  access size, fixed 2'b00 (word)
  mem_busy  in  1  memory cannot take a request this cycle
  fetch_pc  in  ADDR_W  PC from fetch stage
  stall  out  1  fetch stall
  pc_dec  out  ADDR_W  PC paired with instruction at decode
  pc_exec  out  ADDR_W  PC presented to execute
  valid_insn  out  1  decode output is a real instruction
  word_count  out  CNT_W  words loaded
  overflow  out  1  image exceeded MAX_WORDS
  run_done  out  1  run of word_count instructions complete
  checksum  out  DATA_W  running XOR of loaded words

Function
REQ-006 SHALL implement states IDLE, LOAD, PRIME0, PRIME1, RUN, DONE; all outputs registered.
REQ-007 IDLE: s_ready=0, stall=1, mem_wren=0; start -> LOAD, clearing word_count, overflow, checksum, run_done.
REQ-008 LOAD: s_ready = !mem_busy && word_count<MAX_WORDS; start ignored.
REQ-009 On accept, next cycle SHALL drive mem_wren=1, mem_addr=START_ADDRESS+4*word_count(pre-increment), mem_data=s_data; word_count increments (1-cycle latency).
REQ-010 mem_wren SHALL be 0 in any cycle without a preceding-cycle accept; write addresses SHALL be contiguous, no gaps.
REQ-011 Accept with s_last -> PRIME0 after the write cycle.
REQ-012 word_count reaching MAX_WORDS without s_last SHALL set overflow (sticky) and -> PRIME0; further s_valid ignored (s_ready=0).
REQ-013 PRIME0/PRIME1/RUN each cycle: stall=0, mem_wren=0, mem_addr<=fetch_pc, pc_exec<=fetch_pc, pc_dec<=pc_exec.
REQ-014 valid_insn SHALL assert from the second RUN cycle (two priming cycles plus one RUN cycle of fill) and stay high through RUN.
REQ-015 RUN SHALL count advancing cycles; after word_count advances -> DONE.
REQ-016 mem_busy=1 in PRIME0/PRIME1/RUN: stall=1, mem_addr/pc_dec/pc_exec/run counter held, valid_insn held, no state advance.
REQ-017 DONE: stall=1, valid_insn=0, run_done=1 (sticky); start -> LOAD as REQ-007.
REQ-018 mem_enable SHALL be 1 in all states except IDLE; mem_acc_size constant 2'b00.
REQ-019 Simultaneous s_last and word_count reaching MAX_WORDS: s_last wins, overflow stays 0.

Reset
REQ-020 reset SHALL force IDLE asynchronously, from any state including mid-LOAD or mid-RUN, discarding partial counts.
REQ-021 Reset values: s_ready=0, stall=1, mem_wren=0, mem_enable=0, mem_acc_size=2'b00, mem_addr=START_ADDRESS, mem_data=0, pc_dec=0, pc_exec=0, valid_insn=0, word_count=0, overflow=0, run_done=0, checksum=0.

Configuration
REQ-022 Macro PROGRAM_LOADER_CHECKSUM_EN defined: checksum SHALL XOR each accepted word, updating with the write cycle.
REQ-023 Macro undefined: checksum SHALL be constant 0 and no checksum register synthesised.

Verification
REQ-024 Stream 4 words A,B,C,D (D with s_last), mem_busy=0 -> writes at 80020000,80020004,80020008,8002000C, word_count=4, checksum=A^B^C^D (macro on) / 0 (off).
REQ-025 mem_busy high 3 cycles mid-LOAD -> s_ready=0 those cycles, no word lost or duplicated, addresses contiguous.
REQ-026 MAX_WORDS=4, offer 6 words no s_last -> 4 writes, overflow=1, 5th word never accepted; MAX_WORDS=4 with s_last on word 4 -> overflow=0.
REQ-027 After 4-word load, fetch_pc stepping by 4 -> valid_insn high from second RUN cycle, pc_dec lags pc_exec by 1 cycle, run_done=1 after 4 RUN advances, stall=1.
REQ-028 reset asserted mid-RUN -> immediate IDLE, all outputs at REQ-021 values; new start reloads from 80020000.
